ddr_rd_burst_mch: RTL
=====================

Name: ddr_rd_burst_mch

Overview:
Multi-channel successor to the single-channel DDR read burst requester. It serves CH_NUM independent ring-buffer regions in DDR using a round-robin arbiter, and gates each channel on data availability and on downstream credit. Read data returns tagged with its channel and optionally segment-reversed. It sits between the DDR user-interface read port and the per-channel readout FIFOs, all in the ddr_clk domain.

Parameters:
CH_NUM, 4, number of channels (2..8)
DDR_DATA_WD, 512, DDR beat width
SEG_WD, 128, segment width for lane reversal; must divide DDR_DATA_WD
DDR_ADDR_WD, 32, address and block-counter width
BURST_LEN, 16, beats per burst; power of 2
BASE_ADDR, 32'h0, byte address of channel 0 region
CH_SPAN, 32'h1000, blocks per channel region; power of 2, multiple of BURST_LEN
ADDR_SHIFT, 3, left shift from block index to DDR address
CREDIT_MAX, 64, downstream buffer depth in beats per channel; ≥ BURST_LEN
SEG_REV, 1, 1 = reverse SEG_WD segment order on output data

Ports:
ddr_clk  in  1  sole clock
ddr_rst_n  in  1  asynchronous active-low reset
ch_en  in  CH_NUM  per-channel enable
ch_cfg_rst  in  CH_NUM  synchronous per-channel clear, level
rd_avail_blk  in  CH_NUM*DDR_ADDR_WD  per-channel free-running count of blocks written
credit_ret  in  CH_NUM  one pulse per beat consumed downstream
rd_burst_req  out  1  burst request, held until ack
rd_burst_ack  in  1  request accepted
rd_burst_len  out  10  constant BURST_LEN
rd_burst_addr  out  DDR_ADDR_WD  burst start address
rd_burst_data_valid  in  1  read beat valid
rd_burst_data  in  DDR_DATA_WD  read beat
rd_burst_finish  in  1  burst complete pulse
out_valid  out  1  tagged beat valid
out_ch  out  $clog2(CH_NUM)  channel tag
out_data  out  DDR_DATA_WD  beat, segment-reordered if SEG_REV
rd_glb_blk_cnt  out  CH_NUM*DDR_ADDR_WD  per-channel blocks read (free-running)
err_flag  out  2  sticky: [0] beat-count mismatch, [1] credit overflow

Behaviour:
- Reset values: all outputs 0; credits = CREDIT_MAX; arbiter pointer = channel 0; FSM = IDLE.
- Eligibility of ch i: ch_en[i] & ~ch_cfg_rst[i] & (rd_avail_blk[i] - rd_glb_blk_cnt[i], DDR_ADDR_WD-bit modular) ≥ BURST_LEN & credit[i] ≥ BURST_LEN.
- FSM IDLE: any eligible channel → ARB. ARB: grant the first eligible channel at or after the pointer, register its channel number and address, and subtract BURST_LEN from its credit; → REQ. Pointer advances to grant+1 mod CH_NUM.
- REQ: rd_burst_req=1 and the address is stable; on rd_burst_ack → DATA. No new request is raised while one is outstanding; at most one burst is in flight.
- DATA: each rd_burst_data_valid increments the beat counter, and one cycle later out_valid=1 with out_ch set to the granted channel. On rd_burst_finish: rd_glb_blk_cnt[ch] += BURST_LEN; if beat count (including a beat in the same cycle) ≠ BURST_LEN, set err_flag[0]; → IDLE. Minimum gap between bursts is 2 cycles (IDLE, ARB).
- Address = BASE_ADDR + ((ch*CH_SPAN + (rd_glb_blk_cnt[ch] & (CH_SPAN-1))) << ADDR_SHIFT). Wrap is implicit through the mask; the counter itself free-runs and wraps mod 2^DDR_ADDR_WD.
- Credit: credit_ret adds 1 per cycle. The same-cycle grant subtract and return add are applied as a net change. If the result would exceed CREDIT_MAX, saturate and set err_flag[1].
- ch_cfg_rst[i]: rd_glb_blk_cnt[i]=0, credit[i]=CREDIT_MAX, channel ineligible while asserted. If ch i is in flight, the burst completes on the bus, but out_valid is suppressed for the remaining beats and the counter is not advanced at finish.
- out_data: with SEG_REV=1, output segment k = input segment (RATE-1-k), where RATE = DDR_DATA_WD/SEG_WD. With SEG_REV=0, pass-through.
- Async reset mid-burst returns the block to the reset state immediately; the DDR side must be reset together with it.

Test Plan:
- Single ch0 with avail=16 and full credit → one req at addr BASE_ADDR; 16 out_valid tagged ch0; rd_glb_blk_cnt[0]=16; then no further request.
- All 4 channels eligible with avail=64 → grants in order 0,1,2,3,0; ch2 first address = 2*0x1000<<3 = 0x10000.
- ch1 at rd_glb_blk_cnt=0xFF0, CH_SPAN=0x1000 → addresses 0x8000+0x7F80, then 0x8000+0x0000 after wrap; counter reaches 0x1000.
- Credit gating: CREDIT_MAX=32 with no credit_ret → exactly 2 bursts, then stall; 16 credit_ret pulses → third burst issued.
- ch_cfg_rst[0] asserted mid-DATA → remaining beats produce no out_valid; counter=0 and credit=CREDIT_MAX after release.
- Finish after 15 beats → err_flag[0]=1 and held; 17 credit_ret pulses on an idle full channel → err_flag[1]=1, credit stays at CREDIT_MAX.

Source files
------------

// File: rtl/ddr_rd_burst_mch_if.sv
// DDR UI read-burst port plus tagged readout stream for ddr_rd_burst_mch.
// master = burst requester side, slave = DDR controller / readout side.
interface ddr_rd_burst_mch_if #(
    parameter int DDR_DATA_WD = 512,
    parameter int DDR_ADDR_WD = 32,
    parameter int CH_W        = 2
);
    logic                   rd_burst_req;
    logic                   rd_burst_ack;
    logic [9:0]             rd_burst_len;
    logic [DDR_ADDR_WD-1:0] rd_burst_addr;
    logic                   rd_burst_data_valid;
    logic [DDR_DATA_WD-1:0] rd_burst_data;
    logic                   rd_burst_finish;
    logic                   out_valid;
    logic [CH_W-1:0]        out_ch;
    logic [DDR_DATA_WD-1:0] out_data;

    modport master (
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        output out_valid, out_ch, out_data,
        input  rd_burst_ack, rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );

    modport slave (
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        input  out_valid, out_ch, out_data,
        output rd_burst_ack, rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );
endinterface

// File: rtl/ddr_rd_burst_mch.sv
// Multi-channel DDR read burst requester: round-robin over ring-buffer regions, tagged readout.
// Latency: request 2 cycles after eligibility (IDLE, ARB); out_valid 1 cycle after each read beat.
// Backpressure: per-channel credits (returned per consumed beat) gate grants; no stall on the beat path.
module ddr_rd_burst_mch #(
    parameter int                     CH_NUM      = 4,
    parameter int                     DDR_DATA_WD = 512,
    parameter int                     SEG_WD      = 128,
    parameter int                     DDR_ADDR_WD = 32,
    parameter int                     BURST_LEN   = 16,
    parameter logic [DDR_ADDR_WD-1:0] BASE_ADDR   = '0,
    parameter logic [DDR_ADDR_WD-1:0] CH_SPAN     = 'h1000,
    parameter int                     ADDR_SHIFT  = 3,
    parameter int                     CREDIT_MAX  = 64,
    parameter int                     SEG_REV     = 1
) (
    input  logic                            ddr_clk,
    input  logic                            ddr_rst_n,
    input  logic [CH_NUM-1:0]               ch_en_i,
    input  logic [CH_NUM-1:0]               ch_cfg_rst_i,
    input  logic [CH_NUM*DDR_ADDR_WD-1:0]   rd_avail_blk_i,
    input  logic [CH_NUM-1:0]               credit_ret_i,
    ddr_rd_burst_mch_if.master              bus,
    output logic [CH_NUM*DDR_ADDR_WD-1:0]   rd_glb_blk_cnt_o,
    output logic [1:0]                      err_flag_o
);
    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int RATE  = DDR_DATA_WD / SEG_WD;
    localparam int CRD_W = $clog2(CREDIT_MAX + 1) + 1;
    localparam int BC_W  = $clog2(BURST_LEN + 1) + 1;

    localparam logic [CRD_W:0]         CRD_MAX_X = (CRD_W+1)'(CREDIT_MAX);
    localparam logic [CRD_W:0]         CRD_BL_X  = (CRD_W+1)'(BURST_LEN);
    localparam logic [CRD_W-1:0]       CRD_MAX   = CRD_W'(CREDIT_MAX);
    localparam logic [CRD_W-1:0]       CRD_BL    = CRD_W'(BURST_LEN);
    localparam logic [DDR_ADDR_WD-1:0] BL_A      = DDR_ADDR_WD'(BURST_LEN);
    localparam logic [DDR_ADDR_WD-1:0] SPAN_MSK  = CH_SPAN - 1'b1;
    localparam logic [BC_W:0]          BL_BC     = (BC_W+1)'(BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_DATA} state_t;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ptr_q, ptr_d;
    logic [CH_W-1:0]           gnt_q, gnt_d;
    logic [DDR_ADDR_WD-1:0]    addr_q, addr_d;
    logic [BC_W-1:0]           beat_q, beat_d;
    logic                      abort_q, abort_d;
    logic                      out_vld_q, out_vld_d;
    logic [CH_W-1:0]           out_ch_q, out_ch_d;
    logic [DDR_DATA_WD-1:0]    out_dat_q, out_dat_d;
    logic [1:0]                err_q, err_d;
    logic [CRD_W-1:0]          credit_q [CH_NUM];
    logic [CRD_W-1:0]          credit_d [CH_NUM];
    logic [DDR_ADDR_WD-1:0]    glb_q    [CH_NUM];
    logic [DDR_ADDR_WD-1:0]    glb_d    [CH_NUM];

    logic [CH_NUM-1:0]         elig;
    logic                      found;
    logic [CH_W-1:0]           pick;
    logic [DDR_ADDR_WD-1:0]    addr_new;
    logic                      arb_fire;
    logic                      fin;
    logic                      gnt_rst;
    logic [BC_W:0]             beat_tot;
    logic [DDR_DATA_WD-1:0]    rev_dat;

    // Fill level is modular so it stays correct across counter wrap.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_elig
        logic [DDR_ADDR_WD-1:0] fill;
        assign fill    = rd_avail_blk_i[i*DDR_ADDR_WD +: DDR_ADDR_WD] - glb_q[i];
        assign elig[i] = ch_en_i[i] & ~ch_cfg_rst_i[i] & (fill >= BL_A) & (credit_q[i] >= CRD_BL);
        assign rd_glb_blk_cnt_o[i*DDR_ADDR_WD +: DDR_ADDR_WD] = glb_q[i];
    end

    for (genvar k = 0; k < RATE; k++) begin : g_seg
        if (SEG_REV != 0) begin : g_rev
            assign rev_dat[k*SEG_WD +: SEG_WD] = bus.rd_burst_data[(RATE-1-k)*SEG_WD +: SEG_WD];
        end else begin : g_pass
            assign rev_dat[k*SEG_WD +: SEG_WD] = bus.rd_burst_data[k*SEG_WD +: SEG_WD];
        end
    end

    // First eligible channel at or after the round-robin pointer.
    always_comb begin
        int j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 0; k < CH_NUM; k++) begin
            j = int'(ptr_q) + k;
            if (j >= CH_NUM) j = j - CH_NUM;
            if (!found && elig[j]) begin
                found = 1'b1;
                pick  = CH_W'(j);
            end
        end
    end

    assign addr_new = BASE_ADDR
                    + (((DDR_ADDR_WD'(pick) * CH_SPAN) + (glb_q[pick] & SPAN_MSK)) << ADDR_SHIFT);

    always_comb begin
        int nx;
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        arb_fire = 1'b0;
        nx       = int'(pick) + 1;
        if (nx >= CH_NUM) nx = 0;
        case (state_q)
            S_IDLE: if (|elig) state_d = S_ARB;
            S_ARB: begin
                if (found) begin
                    arb_fire = 1'b1;
                    gnt_d    = pick;
                    addr_d   = addr_new;
                    ptr_d    = CH_W'(nx);
                    state_d  = S_REQ;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_REQ:  if (bus.rd_burst_ack) state_d = S_DATA;
            S_DATA: if (bus.rd_burst_finish) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
        if (!ddr_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
        end
    end

    assign fin      = (state_q == S_DATA) & bus.rd_burst_finish;
    assign gnt_rst  = ch_cfg_rst_i[gnt_q];
    assign beat_tot = {1'b0, beat_q} + (BC_W+1)'(bus.rd_burst_data_valid);

    always_comb begin
        logic [CRD_W:0] sum;
        logic           ovf;
        sum       = '0;
        ovf       = 1'b0;
        beat_d    = beat_q;
        abort_d   = abort_q;
        out_vld_d = 1'b0;
        out_ch_d  = out_ch_q;
        out_dat_d = out_dat_q;
        err_d     = err_q;

        // A channel cleared while its burst is in flight lets the bus transfer finish silently.
        if (arb_fire)
            abort_d = 1'b0;
        else if ((state_q == S_REQ || state_q == S_DATA) && gnt_rst)
            abort_d = 1'b1;

        if (state_q == S_REQ)
            beat_d = '0;
        else if (state_q == S_DATA && bus.rd_burst_data_valid && beat_q != {BC_W{1'b1}})
            beat_d = beat_q + 1'b1;

        if (state_q == S_DATA && bus.rd_burst_data_valid && !abort_q && !gnt_rst) begin
            out_vld_d = 1'b1;
            out_ch_d  = gnt_q;
            out_dat_d = rev_dat;
        end

        if (fin && beat_tot != BL_BC)
            err_d[0] = 1'b1;

        for (int i = 0; i < CH_NUM; i++) begin
            sum = {1'b0, credit_q[i]} + (CRD_W+1)'(credit_ret_i[i]);
            if (arb_fire && pick == CH_W'(i))
                sum = sum - CRD_BL_X;
            if (ch_cfg_rst_i[i]) begin
                credit_d[i] = CRD_MAX;
            end else if (sum > CRD_MAX_X) begin
                credit_d[i] = CRD_MAX;
                ovf         = 1'b1;
            end else begin
                credit_d[i] = sum[CRD_W-1:0];
            end

            if (ch_cfg_rst_i[i])
                glb_d[i] = '0;
            else if (fin && !abort_q && gnt_q == CH_W'(i))
                glb_d[i] = glb_q[i] + BL_A;
            else
                glb_d[i] = glb_q[i];
        end
        if (ovf) err_d[1] = 1'b1;
    end

    always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
        if (!ddr_rst_n) begin
            beat_q    <= '0;
            abort_q   <= 1'b0;
            out_vld_q <= 1'b0;
            out_ch_q  <= '0;
            out_dat_q <= '0;
            err_q     <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                credit_q[i] <= CRD_MAX;
                glb_q[i]    <= '0;
            end
        end else begin
            beat_q    <= beat_d;
            abort_q   <= abort_d;
            out_vld_q <= out_vld_d;
            out_ch_q  <= out_ch_d;
            out_dat_q <= out_dat_d;
            err_q     <= err_d;
            for (int i = 0; i < CH_NUM; i++) begin
                credit_q[i] <= credit_d[i];
                glb_q[i]    <= glb_d[i];
            end
        end
    end

    assign bus.rd_burst_req  = (state_q == S_REQ);
    assign bus.rd_burst_len  = 10'(BURST_LEN);
    assign bus.rd_burst_addr = addr_q;
    assign bus.out_valid     = out_vld_q;
    assign bus.out_ch        = out_ch_q;
    assign bus.out_data      = out_dat_q;
    assign err_flag_o        = err_q;
endmodule
